// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and default timing constants for the Morse
//                decode path (symbol decoder and downstream character lookup).
//                Provides the decoder state encoding, the dot/dash symbol
//                values and the default unit timing.
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    // Decoder state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MARK      = 2'd1,
        ST_SPACE     = 2'd2,
        ST_WAIT_WORD = 2'd3
    } state_t;

    // Symbol values as packed into the letter pattern
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // Default timing, shared with the lookup stage
    localparam int UNIT_CYCLES = 5_000_000;
    localparam int DASH_UNITS  = 2;
    localparam int LETTER_GAP  = 3;
    localparam int WORD_GAP    = 7;
    localparam int MAX_SYMS    = 5;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_symbol_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_decoder_if
//  Description : Key input / letter output bundle of the Morse symbol decoder.
//                master : key source side (drives key_in, src_clr; observes
//                         the letter/word strobes).
//                slave  : decoder side.
//  Signals     : key_in, src_clr            -> decoder
//                sym_valid, sym_code, sym_len, sym_err, word_valid, busy
//                                           <- decoder
//  Revision    : 1.0 - initial release
// ============================================================================
interface morse_symbol_decoder_if #(
    parameter int MAX_SYMS = morse_pkg::MAX_SYMS
) ();

    logic                key_in;
    logic                src_clr;
    logic                sym_valid;
    logic [MAX_SYMS-1:0] sym_code;
    logic [2:0]          sym_len;
    logic                sym_err;
    logic                word_valid;
    logic                busy;

    modport master (
        output key_in,
        output src_clr,
        input  sym_valid,
        input  sym_code,
        input  sym_len,
        input  sym_err,
        input  word_valid,
        input  busy
    );

    modport slave (
        input  key_in,
        input  src_clr,
        output sym_valid,
        output sym_code,
        output sym_len,
        output sym_err,
        output word_valid,
        output busy
    );

endinterface : morse_symbol_decoder_if
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_unit_timer
//  Description : Morse time-unit prescaler. Counts 0..UNIT_CYCLES-1 and wraps
//                while running; restarts from 0 on every key edge so that unit
//                boundaries are aligned to the start of each mark or gap.
//  Ports       : clk        - system clock
//                rst        - synchronous active-high clear
//                i_run      - count enable; counter held at 0 when low
//                i_edge_clr - key edge seen this cycle, restart the unit
//                o_tick     - high in the cycle the counter is at its last value
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_unit_timer #(
    parameter int UNIT_CYCLES = morse_pkg::UNIT_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    input  wire logic i_edge_clr,
    output logic      o_tick
);

    localparam int              c_pw   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [c_pw-1:0] c_term = c_pw'(UNIT_CYCLES - 1);

    logic [c_pw-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_edge_clr || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Gated by i_run so a one-cycle unit cannot tick while idle.
    assign o_tick = i_run && (r_cnt == c_term);

endmodule : morse_unit_timer
`default_nettype wire

// File: rtl/morse_symbol_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_decoder
//  Description : Times key-down marks and key-up gaps in Morse units,
//                classifies marks as dot/dash, packs them into a per-letter
//                pattern and emits a letter strobe after a letter gap and a
//                word strobe after a word gap.
//  Ports       : clk     - system clock
//                ext_rst - synchronous active-high reset
//                bus     - slave side of morse_symbol_decoder_if:
//                          key_in/src_clr in; sym_valid, sym_code, sym_len,
//                          sym_err, word_valid, busy out (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_symbol_decoder #(
    parameter int UNIT_CYCLES = morse_pkg::UNIT_CYCLES,
    parameter int DASH_UNITS  = morse_pkg::DASH_UNITS,
    parameter int LETTER_GAP  = morse_pkg::LETTER_GAP,
    parameter int WORD_GAP    = morse_pkg::WORD_GAP,
    parameter int MAX_SYMS    = morse_pkg::MAX_SYMS,
    parameter int CNT_W       = 4
) (
    input  wire logic              clk,
    input  wire logic              ext_rst,
    morse_symbol_decoder_if.slave  bus
);

    import morse_pkg::*;

    localparam logic [CNT_W-1:0] c_dash_units = CNT_W'(DASH_UNITS);
    localparam logic [CNT_W-1:0] c_letter_gap = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] c_word_gap   = CNT_W'(WORD_GAP);
    localparam logic [2:0]       c_max_syms   = 3'(MAX_SYMS);

    state_t              r_state;
    logic                r_key_q;
    logic [CNT_W-1:0]    r_mark_cnt;
    logic [CNT_W-1:0]    r_gap_cnt;
    logic [MAX_SYMS-1:0] r_pattern;
    logic [2:0]          r_len;
    logic                r_err;

    logic                r_sym_valid;
    logic [MAX_SYMS-1:0] r_sym_code;
    logic [2:0]          r_sym_len;
    logic                r_sym_err;
    logic                r_word_valid;
    logic                r_busy;

    logic                w_rise;
    logic                w_fall;
    logic                w_tick;
    logic                w_clr;
    logic                w_run;
    logic [CNT_W-1:0]    w_mark_inc;
    logic [CNT_W-1:0]    w_gap_inc;
    logic                w_sym;

    assign w_rise = bus.key_in & ~r_key_q;
    assign w_fall = ~bus.key_in & r_key_q;
    assign w_clr  = ext_rst | bus.src_clr;
    assign w_run  = (r_state != ST_IDLE);

    // Unit counters stick at all-ones instead of wrapping on long marks/gaps.
    assign w_mark_inc = (r_mark_cnt == '1) ? r_mark_cnt : r_mark_cnt + 1'b1;
    assign w_gap_inc  = (r_gap_cnt  == '1) ? r_gap_cnt  : r_gap_cnt  + 1'b1;
    assign w_sym      = (r_mark_cnt >= c_dash_units) ? SYM_DASH : SYM_DOT;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (w_clr),
        .i_run      (w_run),
        .i_edge_clr (w_rise | w_fall),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk) begin
        if (ext_rst || bus.src_clr) begin
            // A source switch keeps tracking the key so that a key already held
            // down on the new source is not seen as a fresh rise.
            r_key_q      <= ext_rst ? 1'b0 : bus.key_in;
            r_state      <= ST_IDLE;
            r_mark_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_pattern    <= '0;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_sym_valid  <= 1'b0;
            r_sym_code   <= '0;
            r_sym_len    <= '0;
            r_sym_err    <= 1'b0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_key_q      <= bus.key_in;
            r_sym_valid  <= 1'b0;
            r_word_valid <= 1'b0;
            r_busy       <= (r_state == ST_MARK) || (r_state == ST_SPACE);

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state    <= ST_MARK;
                        r_mark_cnt <= '0;
                    end
                end

                ST_MARK: begin
                    // The fall classifies the mark from the units already
                    // counted; a tick landing on the same cycle is not added.
                    if (w_fall) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_SPACE;
                        if (r_mark_cnt == '0) begin
                            // Sub-unit glitch: no symbol. With nothing
                            // collected yet there is no letter to time out.
                            if (r_len == '0) begin
                                r_state <= ST_IDLE;
                            end
                        end else if (r_len < c_max_syms) begin
                            r_pattern <= (r_pattern << 1) | MAX_SYMS'(w_sym);
                            r_len     <= r_len + 3'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_mark_cnt <= w_mark_inc;
                    end
                end

                ST_SPACE: begin
                    // A rise beats a coinciding letter-gap tick.
                    if (w_rise) begin
                        r_state    <= ST_MARK;
                        r_mark_cnt <= '0;
                    end else if (w_tick) begin
                        r_gap_cnt <= w_gap_inc;
                        if (w_gap_inc == c_letter_gap) begin
                            r_sym_valid <= 1'b1;
                            r_sym_code  <= r_pattern;
                            r_sym_len   <= r_len;
                            r_sym_err   <= r_err;
                            r_pattern   <= '0;
                            r_len       <= '0;
                            r_err       <= 1'b0;
                            r_state     <= ST_WAIT_WORD;
                        end
                    end
                end

                ST_WAIT_WORD: begin
                    if (w_rise) begin
                        r_state    <= ST_MARK;
                        r_mark_cnt <= '0;
                    end else if (w_tick) begin
                        r_gap_cnt <= w_gap_inc;
                        if (w_gap_inc == c_word_gap) begin
                            r_word_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sym_valid  = r_sym_valid;
    assign bus.sym_code   = r_sym_code;
    assign bus.sym_len    = r_sym_len;
    assign bus.sym_err    = r_sym_err;
    assign bus.word_valid = r_word_valid;
    assign bus.busy       = r_busy;

endmodule : morse_symbol_decoder
`default_nettype wire

// File: tb/tb_morse_symbol_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_symbol_decoder
//  Description : Self-checking bench for morse_symbol_decoder with a 4-cycle
//                time unit. Table of letters plus hand-written sequences for
//                word timing, glitches, clears and edge/tick coincidence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_decoder;

    typedef struct packed {
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } exp_t;

    typedef struct {
        int         nsym;
        logic [5:0] dash;   // bit i = symbol i in send order, 1 = dash
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } vec_t;

    localparam int c_nv = 9;

    logic clk = 1'b0;
    logic ext_rst;

    always #5 clk = ~clk;

    morse_symbol_decoder_if #(.MAX_SYMS(5)) bus ();

    morse_symbol_decoder #(
        .UNIT_CYCLES (4),
        .DASH_UNITS  (2),
        .LETTER_GAP  (3),
        .WORD_GAP    (7),
        .MAX_SYMS    (5),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .ext_rst (ext_rst),
        .bus     (bus)
    );

    int   n_checks    = 0;
    int   n_pass      = 0;
    int   sym_cnt     = 0;
    int   word_cnt    = 0;
    int   overlap_cnt = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs [c_nv];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Output monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.sym_valid && bus.word_valid) overlap_cnt++;
        if (bus.word_valid) word_cnt++;
        if (bus.sym_valid) begin
            sym_cnt++;
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_sym_valid: got strobe code=%b len=%0d err=%0b, expected none",
                         bus.sym_code, bus.sym_len, bus.sym_err);
            end else begin
                mon_e = sbq.pop_front();
                chk("sym_code", 32'(bus.sym_code), 32'(mon_e.code));
                chk("sym_len",  32'(bus.sym_len),  32'(mon_e.len));
                chk("sym_err",  32'(bus.sym_err),  32'(mon_e.err));
            end
        end
    end

    task automatic drive(input logic lvl, input int n);
        bus.key_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_sym(input logic [4:0] code, input logic [2:0] len, input logic err);
        exp_t t;
        t.code = code;
        t.len  = len;
        t.err  = err;
        sbq.push_back(t);
    endtask

    // Sends symbols with one-unit inter-symbol gaps, then a letter gap.
    task automatic send_letter(input int nsym, input logic [5:0] dash);
        for (int i = 0; i < nsym; i++) begin
            drive(1'b1, dash[i] ? 9 : 5);
            if (i < nsym - 1) drive(1'b0, 5);
        end
        drive(1'b0, 14);
    endtask

    task automatic pulse_clear(input logic use_rst);
        if (use_rst) ext_rst = 1'b1;
        else         bus.src_clr = 1'b1;
        @(posedge clk);
        #1;
        ext_rst     = 1'b0;
        bus.src_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int s0, w0;

        vecs[0] = '{1, 6'b000000, 5'b00000, 3'd1, 1'b0}; // E
        vecs[1] = '{1, 6'b000001, 5'b00001, 3'd1, 1'b0}; // T
        vecs[2] = '{2, 6'b000001, 5'b00010, 3'd2, 1'b0}; // N
        vecs[3] = '{4, 6'b000001, 5'b01000, 3'd4, 1'b0}; // B
        vecs[4] = '{5, 6'b011010, 5'b01011, 3'd5, 1'b0}; // .-.--
        vecs[5] = '{5, 6'b011111, 5'b11111, 3'd5, 1'b0}; // 0
        vecs[6] = '{6, 6'b111111, 5'b11111, 3'd5, 1'b1}; // six dashes
        vecs[7] = '{6, 6'b100000, 5'b00000, 3'd5, 1'b1}; // five dots + dash
        vecs[8] = '{3, 6'b000100, 5'b00001, 3'd3, 1'b0}; // U

        bus.key_in  = 1'b0;
        bus.src_clr = 1'b0;
        ext_rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym_valid",  32'(bus.sym_valid),  0);
        chk("rst_sym_code",   32'(bus.sym_code),   0);
        chk("rst_sym_len",    32'(bus.sym_len),    0);
        chk("rst_sym_err",    32'(bus.sym_err),    0);
        chk("rst_word_valid", 32'(bus.word_valid), 0);
        chk("rst_busy",       32'(bus.busy),       0);
        ext_rst = 1'b0;
        drive(1'b0, 2);

        // Table of letters, each followed by a full word gap.
        for (int i = 0; i < c_nv; i++) begin
            s0 = sym_cnt;
            w0 = word_cnt;
            expect_sym(vecs[i].code, vecs[i].len, vecs[i].err);
            send_letter(vecs[i].nsym, vecs[i].dash);
            chk("vec_pending", sbq.size(), 0);
            chk("vec_sym_count", sym_cnt - s0, 1);
            drive(1'b0, 20);
            chk("vec_word_count", word_cnt - w0, 1);
            chk("vec_busy_idle", 32'(bus.busy), 0);
        end

        // "A" with word-gap timing: no word strobe at 28 low cycles, one after.
        s0 = sym_cnt;
        w0 = word_cnt;
        expect_sym(5'b00001, 3'd2, 1'b0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        drive(1'b1, 9);
        drive(1'b0, 14);
        chk("a_sym_count", sym_cnt - s0, 1);
        drive(1'b0, 14);
        chk("a_no_word_early", word_cnt - w0, 0);
        drive(1'b0, 3);
        chk("a_word_once", word_cnt - w0, 1);
        drive(1'b0, 10);
        chk("a_word_still_once", word_cnt - w0, 1);

        // Glitch from idle: no strobes, busy returns low.
        s0 = sym_cnt;
        w0 = word_cnt;
        drive(1'b1, 2);
        chk("glitch_busy_high", 32'(bus.busy), 1);
        drive(1'b0, 40);
        chk("glitch_no_sym", sym_cnt - s0, 0);
        chk("glitch_no_word", word_cnt - w0, 0);
        chk("glitch_busy_low", 32'(bus.busy), 0);

        // Clear mid-letter via src_clr, then via ext_rst.
        for (int k = 0; k < 2; k++) begin
            s0 = sym_cnt;
            w0 = word_cnt;
            drive(1'b1, 5);
            drive(1'b0, 5);
            drive(1'b1, 5);
            drive(1'b0, 6);
            pulse_clear(k == 1);
            chk("clr_sym_len",    32'(bus.sym_len),    0);
            chk("clr_sym_code",   32'(bus.sym_code),   0);
            chk("clr_sym_err",    32'(bus.sym_err),    0);
            chk("clr_sym_valid",  32'(bus.sym_valid),  0);
            chk("clr_word_valid", 32'(bus.word_valid), 0);
            chk("clr_busy",       32'(bus.busy),       0);
            drive(1'b0, 40);
            chk("clr_no_sym", sym_cnt - s0, 0);
            chk("clr_no_word", word_cnt - w0, 0);
            expect_sym(5'b00000, 3'd1, 1'b0);
            send_letter(1, 6'b000000);
            chk("clr_after_sym", sym_cnt - s0, 1);
            chk("clr_after_pending", sbq.size(), 0);
            drive(1'b0, 20);
        end

        // Rise exactly on the letter-gap tick: letter continues.
        s0 = sym_cnt;
        expect_sym(5'b00000, 3'd2, 1'b0);
        drive(1'b1, 5);
        drive(1'b0, 12);
        drive(1'b1, 5);
        drive(1'b0, 14);
        chk("coinc_sym_count", sym_cnt - s0, 1);
        chk("coinc_pending", sbq.size(), 0);
        drive(1'b0, 20);

        chk("no_strobe_overlap", overlap_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_morse_symbol_decoder
`default_nettype wire
